// File: rtl/lrn_window_buffer.sv
// Cross-channel LRN window: buffers GLB read words, tracks the sum of squares,
// hands {center, sum} to the divider and slides once the divider answers.
module lrn_window_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned WINDOW     = 5,
    parameter int unsigned PTR_WIDTH  = 3,
    parameter int unsigned SUM_WIDTH  = 35
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic                  start_normalization,
    input  logic                  r_enable,
    input  logic [DATA_WIDTH-1:0] glb_rdata,
    output logic                  full_flag,
    output logic                  div_in_valid,
    input  logic                  div_in_ready,
    output logic [DATA_WIDTH-1:0] div_num,
    output logic [SUM_WIDTH-1:0]  div_den,
    input  logic                  div_out_valid,
    output logic                  normalized_window,
    output logic                  overflow_err
);

    localparam logic [PTR_WIDTH-1:0] WinP  = PTR_WIDTH'(WINDOW);
    localparam logic [PTR_WIDTH-1:0] LastP = PTR_WIDTH'(WINDOW - 1);
    localparam logic [PTR_WIDTH-1:0] OneP  = PTR_WIDTH'(1);
    localparam logic [PTR_WIDTH:0]   WinW  = (PTR_WIDTH + 1)'(WINDOW);
    localparam logic [PTR_WIDTH:0]   HalfW = (PTR_WIDTH + 1)'(WINDOW / 2);

    typedef enum logic [1:0] {StFill, StIssue, StWaitDiv, StSlide} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [WINDOW];
    logic                  push_v_q, push_v_d;
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [SUM_WIDTH-1:0]  sum_q, sum_d;
    logic                  full_q, full_d;
    logic                  ovf_q, ovf_d;
    logic                  div_valid_q, div_valid_d;
    logic [DATA_WIDTH-1:0] div_num_q, div_num_d;
    logic [SUM_WIDTH-1:0]  div_den_q, div_den_d;

    logic                  pop, is_full, push_ok, push_ovf;
    logic [SUM_WIDTH-1:0]  new_sq, old_sq;
    logic [PTR_WIDTH:0]    ctr_sum;
    logic [PTR_WIDTH-1:0]  ctr_idx;

    assign pop      = (state_q == StSlide);
    assign is_full  = (cnt_q == WinP);
    // A push into a full window is only legal when the slide frees a slot that cycle.
    assign push_ok  = push_v_q & (~is_full | pop);
    assign push_ovf = push_v_q & is_full & ~pop;
    assign new_sq   = SUM_WIDTH'(glb_rdata) * SUM_WIDTH'(glb_rdata);
    assign old_sq   = SUM_WIDTH'(mem_q[rd_ptr_q]) * SUM_WIDTH'(mem_q[rd_ptr_q]);

    always_comb begin
        ctr_sum = {1'b0, rd_ptr_q} + HalfW;
        if (ctr_sum >= WinW) begin
            ctr_sum = ctr_sum - WinW;
        end
        ctr_idx = ctr_sum[PTR_WIDTH-1:0];
    end

    always_comb begin
        push_v_d = r_enable;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        ovf_d    = ovf_q | push_ovf;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LastP) ? '0 : wr_ptr_q + OneP;
            cnt_d    = cnt_d + OneP;
            sum_d    = sum_d + new_sq;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastP) ? '0 : rd_ptr_q + OneP;
            cnt_d    = cnt_d - OneP;
            sum_d    = sum_d - old_sq;
        end
        if (start_normalization) begin
            push_v_d = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            sum_d    = '0;
            ovf_d    = 1'b0;
        end
        full_d = (cnt_d == WinP);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill:    if (cnt_d == WinP) state_d = StIssue;
            StIssue:   if (div_valid_q && div_in_ready) state_d = StWaitDiv;
            StWaitDiv: if (div_out_valid) state_d = StSlide;
            StSlide:   state_d = StFill;
            default:   state_d = StFill;
        endcase
        if (start_normalization) begin
            state_d = StFill;
        end
    end

    // Request is captured on ISSUE entry and held until the divider takes it.
    always_comb begin
        div_valid_d = div_valid_q;
        div_num_d   = div_num_q;
        div_den_d   = div_den_q;
        if (state_q == StIssue) begin
            if (!div_valid_q) begin
                div_valid_d = 1'b1;
                div_num_d   = mem_q[ctr_idx];
                div_den_d   = sum_q;
            end else if (div_in_ready) begin
                div_valid_d = 1'b0;
            end
        end
        if (start_normalization) begin
            div_valid_d = 1'b0;
            div_num_d   = '0;
            div_den_d   = '0;
        end
    end

    always_ff @(posedge core_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StFill;
            push_v_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            div_valid_q <= 1'b0;
            div_num_q   <= '0;
            div_den_q   <= '0;
        end else begin
            state_q     <= state_d;
            push_v_q    <= push_v_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            div_valid_q <= div_valid_d;
            div_num_q   <= div_num_d;
            div_den_q   <= div_den_d;
        end
    end

    always_ff @(posedge core_clk) begin
        if (push_ok && !start_normalization) begin
            mem_q[wr_ptr_q] <= glb_rdata;
        end
    end

    assign full_flag         = full_q;
    assign div_in_valid      = div_valid_q;
    assign div_num           = div_num_q;
    assign div_den           = div_den_q;
    assign normalized_window = pop;
    assign overflow_err      = ovf_q;

endmodule

// File: doc/lrn_window_buffer.md
Name: lrn_window_buffer

Overview:
- Sits between the GLB read port and the LRN divider.
- Captures each GLB read word issued by the LRN mapper into a cross-channel sliding window of WINDOW entries and keeps a running sum of squares.
- When the window is full, issues {center element, sum of squares} to the divider.
- Signals window completion back to the mapper, then slides the window by one entry.

Parameters:
- DATA_WIDTH, 16, width of one unsigned activation word from GLB.
- WINDOW, 5, LRN local size; must be odd and in the range 3..7.
- PTR_WIDTH, 3, width of the buffer pointers and occupancy count; must satisfy 2^PTR_WIDTH > WINDOW.
- SUM_WIDTH, 35, sum-of-squares width; equals 2*DATA_WIDTH+3.

Ports:
- core_clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- start_normalization  in  1  synchronous clear of buffer, sum, flags and FSM.
- r_enable  in  1  GLB read strobe from the mapper; data returns one cycle later.
- glb_rdata  in  DATA_WIDTH  GLB read data.
- full_flag  out  1  window holds WINDOW entries.
- div_in_valid  out  1  divider request valid.
- div_in_ready  in  1  divider accepts the request.
- div_num  out  DATA_WIDTH  center element of the window.
- div_den  out  SUM_WIDTH  sum of squares over the window.
- div_out_valid  in  1  divider result ready (shared with the mapper).
- normalized_window  out  1  one-cycle pulse: window done, slide occurs.
- overflow_err  out  1  sticky: a push arrived while the window was full.

Behaviour:
- Reset (reset=0) clears all state regardless of clock:
  - outputs: full_flag=0, div_in_valid=0, div_num=0, div_den=0, normalized_window=0, overflow_err=0;
  - internal: occupancy cnt=0, rd_ptr=wr_ptr=0, sum=0, state=FILL.
- start_normalization=1 for one clock applies the same clear synchronously and takes priority over every other event that cycle.
- Push timing:
  - push_v is r_enable delayed one cycle.
  - A push writes glb_rdata to mem[wr_ptr] and wraps wr_ptr modulo WINDOW.
  - On the same cycle: cnt += 1 and sum += glb_rdata^2 (unsigned, computed at full width).
- Pop: mem[rd_ptr] is removed, rd_ptr wraps modulo WINDOW, cnt -= 1, sum -= mem[rd_ptr]^2.
- full_flag is registered and equals (cnt == WINDOW).
- Center element is mem[(rd_ptr + WINDOW/2) mod WINDOW].
- FSM states: FILL, ISSUE, WAIT_DIV, SLIDE.
  - FILL: accept pushes. Transition to ISSUE on the clock at which cnt becomes WINDOW; full_flag rises on that same edge.
  - ISSUE:
    - div_in_valid=1; div_num and div_den are registered and held stable while valid and not ready.
    - On div_in_valid & div_in_ready, drop div_in_valid next cycle and go to WAIT_DIV.
    - Accept/issue latency from full_flag rising is one cycle minimum.
  - WAIT_DIV: wait for div_out_valid; then go to SLIDE.
  - SLIDE (exactly one cycle):
    - normalized_window=1; perform a pop; full_flag=0 next cycle; return to FILL.
- Push while full (cnt == WINDOW and no pop that cycle): data is dropped, overflow_err sets and stays set until reset or start_normalization. cnt and sum are unchanged.
- Push and pop in the same cycle (SLIDE):
  - both apply: cnt unchanged, sum = sum + new^2 - old^2;
  - full_flag stays 1 and the FSM goes FILL->ISSUE on the next cycle;
  - this is not an overflow.
- Push while not full in ISSUE or WAIT_DIV cannot occur because cnt == WINDOW there; any such push is an overflow.
- div_out_valid in FILL or ISSUE is ignored.
- A mid-operation reset or start_normalization discards any outstanding divider request and deasserts div_in_valid immediately. Asynchronously for reset; next edge for start.
- Sum arithmetic:
  - never wraps for legal use: WINDOW * (2^DATA_WIDTH - 1)^2 < 2^SUM_WIDTH;
  - a subtraction result below zero is impossible by construction and need not be handled.

Test Plan:
1. Fill: WINDOW=5, pulse r_enable on 5 consecutive cycles with data 1,2,3,4,5.
   -> full_flag=1 one cycle after the last data cycle; div_in_valid=1 next cycle with div_num=3, div_den=55.
2. Slide: from test 1, div_in_ready=1, then div_out_valid=1.
   -> normalized_window pulses once; cnt=4, sum=54, full_flag=0. Push 6.
   -> div_num=4, div_den=90.
3. Backpressure: hold div_in_ready=0 for 10 cycles.
   -> div_in_valid stays 1 with div_num and div_den constant; accept on cycle 11 leads to WAIT_DIV.
4. Simultaneous push and pop: with the window at {1..5}, r_enable is asserted the cycle before SLIDE with data 6.
   -> cnt stays 5, sum=90, full_flag remains 1, no overflow_err.
5. Overflow: a push of 9 while the window is full in WAIT_DIV.
   -> overflow_err=1 sticky; sum and div_den unchanged; clears only on start_normalization.
6. Mid-operation reset: assert reset=0 during ISSUE without a clock edge.
   -> div_in_valid=0, full_flag=0, overflow_err=0 immediately; after release, FILL with cnt=0.
